// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared state encodings and frame constants for the 8N1 UART.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 receiver with input synchronizer, mid-bit sampling and
//                sticky not-empty / overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic                 i_clear,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_rxne,
    output logic                 o_ore
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX  = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [2:0]          c_BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    rx_state_t            r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_word;
    logic                 r_rxne;
    logic                 r_ore;

    rx_state_t            w_state_nxt;
    logic [c_BAUD_W-1:0]  w_baud_nxt;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_done;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_nxt = RX_START;
                    w_baud_nxt  = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (r_baud == c_BAUD_HALF) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (r_baud == c_BAUD_MAX) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                    if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (r_baud == c_BAUD_MAX) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = RX_IDLE;
                    w_done      = r_sync2;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_rxne  <= 1'b0;
            r_ore   <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            // A completing frame takes priority over a simultaneous clear.
            if (w_done && (!r_rxne || i_clear)) begin
                r_word <= w_shift_nxt;
                r_rxne <= 1'b1;
                r_ore  <= 1'b0;
            end else if (w_done) begin
                r_ore <= 1'b1;
            end else if (i_clear) begin
                r_rxne <= 1'b0;
                r_ore  <= 1'b0;
            end
        end
    end

    assign o_word = r_word;
    assign o_rxne = r_rxne;
    assign o_ore  = r_ore;

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : uart_top
//  Description : Full-duplex 8N1 UART: inline transmitter plus uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic [DATA_BITS-1:0] in_w_data,
    input  logic                 in_valid,
    output logic                 out_BUSY,
    output logic                 out_signal,
    input  logic                 in_signal,
    input  logic                 in_RXNE_clear,
    output logic [DATA_BITS-1:0] out_word,
    output logic                 out_RXNE,
    output logic                 out_Rx_ORE
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t            r_tx_state;
    logic [c_BAUD_W-1:0]  r_tx_baud;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;

    tx_state_t            w_tx_state_nxt;
    logic [c_BAUD_W-1:0]  w_tx_baud_nxt;
    logic [2:0]           w_tx_bit_nxt;
    logic [DATA_BITS-1:0] w_tx_shift_nxt;
    logic                 w_tx_line;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_baud_nxt  = r_tx_baud;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_line      = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (in_valid) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_baud_nxt  = '0;
                    w_tx_shift_nxt = in_w_data;
                end
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (r_tx_baud == c_BAUD_MAX) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                end else begin
                    w_tx_baud_nxt = r_tx_baud + c_BAUD_W'(1);
                end
            end
            TX_DATA: begin
                // The shift register's LSB is always the bit on the wire.
                w_tx_line = r_tx_shift[0];
                if (r_tx_baud == c_BAUD_MAX) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    if (r_tx_bit == c_BIT_LAST) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_baud_nxt = r_tx_baud + c_BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_baud == c_BAUD_MAX) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_tx_baud_nxt = r_tx_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_baud_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_baud  <= w_tx_baud_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
        end
    end

    assign out_signal = w_tx_line;
    assign out_BUSY   = (r_tx_state != TX_IDLE);

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_rx      (in_signal),
        .i_clear   (in_RXNE_clear),
        .o_word    (out_word),
        .o_rxne    (out_RXNE),
        .o_ore     (out_Rx_ORE)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_top
//  Description : Scoreboard bench for uart_top with TX decoder and RX monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_top;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [7:0] in_w_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_BUSY;
    logic       out_signal;
    logic       in_signal;
    logic       in_RXNE_clear = 1'b0;
    logic [7:0] out_word;
    logic       out_RXNE;
    logic       out_Rx_ORE;

    logic       loop = 1'b0;
    logic       rx_drive = 1'b1;
    logic       tx_mon_en = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] last_word = 8'h00;

    assign in_signal = loop ? out_signal : rx_drive;

    always #5 clk = ~clk;

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .in_w_data     (in_w_data),
        .in_valid      (in_valid),
        .out_BUSY      (out_BUSY),
        .out_signal    (out_signal),
        .in_signal     (in_signal),
        .in_RXNE_clear (in_RXNE_clear),
        .out_word      (out_word),
        .out_RXNE      (out_RXNE),
        .out_Rx_ORE    (out_Rx_ORE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_w_data = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (out_BUSY && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("busy_timeout", out_BUSY, 0);
    endtask

    task automatic wait_rxne();
        int c = 0;
        while (!out_RXNE && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("rxne_timeout", out_RXNE, 1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        in_RXNE_clear = 1'b1;
        @(negedge clk);
        in_RXNE_clear = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    // TX monitor: decode each frame on the line mid-bit and score it.
    initial begin
        logic [7:0] b;
        logic       st;
        logic       sp;
        logic [7:0] e;
        forever begin
            @(negedge out_signal);
            repeat (CPB / 2) @(posedge clk);
            #1 st = out_signal;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = out_signal;
            end
            repeat (CPB) @(posedge clk);
            #1 sp = out_signal;
            if (tx_mon_en) begin
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got frame 0x%0h expected none", b);
                end else begin
                    e = tx_exp.pop_front();
                    check("tx_start", st, 0);
                    check("tx_byte", b, e);
                    check("tx_stop", sp, 1);
                end
            end
        end
    end

    // RX monitor: each new not-empty indication must carry the next expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge out_RXNE);
            #1;
            if (rx_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got word 0x%0h expected none", out_word);
            end else begin
                e = rx_exp.pop_front();
                check("rx_word", out_word, e);
            end
        end
    end

    initial begin
        int         cnt;
        logic [9:0] f;

        repeat (5) @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        check("rst_signal", out_signal, 1);
        check("rst_busy", out_BUSY, 0);
        check("rst_word", out_word, 8'h00);
        check("rst_rxne", out_RXNE, 0);
        check("rst_ore", out_Rx_ORE, 0);
        tx_mon_en = 1'b1;

        // 0x41: busy length and per-bit line levels
        tx_exp.push_back(8'h41);
        f = {1'b1, 8'h41, 1'b0};
        send(8'h41);
        cnt = 0;
        while (out_BUSY && cnt < 2000) begin
            if (cnt % CPB == CPB / 2)
                check($sformatf("tx41_bit%0d", cnt / CPB), out_signal, f[cnt/CPB]);
            @(negedge clk);
            cnt++;
        end
        check("tx41_busy_cycles", cnt, 10 * CPB);
        repeat (20) @(negedge clk);

        // Loopback 0x53
        loop = 1'b1;
        tx_exp.push_back(8'h53);
        rx_exp.push_back(8'h53);
        last_word = 8'h53;
        send(8'h53);
        wait_rxne();
        check("lb53_word", out_word, last_word);
        wait_idle();
        pulse_clear();
        check("lb53_clear_rxne", out_RXNE, 0);

        // Loopback overrun 0x31 then 0x34
        tx_exp.push_back(8'h31);
        tx_exp.push_back(8'h34);
        rx_exp.push_back(8'h31);
        last_word = 8'h31;
        send(8'h31);
        wait_idle();
        send(8'h34);
        wait_idle();
        repeat (10) @(negedge clk);
        check("ovr_word", out_word, last_word);
        check("ovr_rxne", out_RXNE, 1);
        check("ovr_ore", out_Rx_ORE, 1);
        pulse_clear();
        check("ovr_clear_rxne", out_RXNE, 0);
        check("ovr_clear_ore", out_Rx_ORE, 0);

        // Request while busy is dropped
        loop = 1'b0;
        repeat (20) @(negedge clk);
        tx_exp.push_back(8'h30);
        send(8'h30);
        repeat (100) @(negedge clk);
        send(8'h52);
        wait_idle();
        repeat (1200) @(negedge clk);
        check("drop_busy", out_BUSY, 0);

        // RX glitch and framing error
        rx_drive = 1'b0;
        repeat (20) @(negedge clk);
        rx_drive = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_rxne", out_RXNE, 0);
        rx_frame(8'hA5, 1'b0);
        check("ferr_rxne", out_RXNE, 0);
        check("ferr_word", out_word, last_word);

        // Direct valid frame on RX
        rx_exp.push_back(8'hC3);
        last_word = 8'hC3;
        rx_frame(8'hC3, 1'b1);
        check("rxc3_rxne", out_RXNE, 1);
        check("rxc3_word", out_word, last_word);

        // Reset mid-TX aborts frame and clears flags
        tx_mon_en = 1'b0;
        send(8'h55);
        repeat (300) @(negedge clk);
        check("pre_rst_busy", out_BUSY, 1);
        i_reset_n = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        check("midrst_signal", out_signal, 1);
        check("midrst_busy", out_BUSY, 0);
        check("midrst_rxne", out_RXNE, 0);
        check("midrst_ore", out_Rx_ORE, 0);
        check("midrst_word", out_word, 8'h00);
        repeat (1200) @(negedge clk);
        check("midrst_stays_idle", out_BUSY, 0);

        check("tx_queue_empty", tx_exp.size(), 0);
        check("rx_queue_empty", rx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
